// File: rtl/rvx_core_state_ctrl.sv
// Core sequencing FSM: picks the next-PC source and drives PC-update, flush, CSR-commit and sleep.
// Commits are same-cycle (Mealy); bus_stall freezes all state and suppresses commits and PC updates.
module rvx_core_state_ctrl #(
  parameter int RESET_HOLD_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       take_trap,
  input  logic       take_mret,
  input  logic       wfi_s1,
  input  logic       interrupt_pending,
  input  logic       bus_stall,
  output logic [3:0] current_state_s1,
  output logic       pc_update_enable,
  output logic       flush_s1,
  output logic       trap_commit,
  output logic       mret_commit,
  output logic       sleeping
);

  typedef enum logic [3:0] {
    RVX_STATE_RESET       = 4'b0001,
    RVX_STATE_OPERATING   = 4'b0010,
    RVX_STATE_TRAP_TAKEN  = 4'b0100,
    RVX_STATE_TRAP_RETURN = 4'b1000
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic       sleeping_q, sleeping_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d     = state_q;
    sleeping_d  = sleeping_q;
    hold_cnt_d  = hold_cnt_q;
    trap_commit = 1'b0;
    mret_commit = 1'b0;
    if (!bus_stall) begin
      case (state_q)
        RVX_STATE_RESET: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = RVX_STATE_OPERATING;
            hold_cnt_d = 4'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        RVX_STATE_OPERATING: begin
          if (sleeping_q) begin
            // Wake-up without a trap resumes at the instruction after WFI.
            if (take_trap) begin
              state_d     = RVX_STATE_TRAP_TAKEN;
              sleeping_d  = 1'b0;
              trap_commit = 1'b1;
            end else if (interrupt_pending) begin
              sleeping_d = 1'b0;
            end
          end else if (take_trap) begin
            state_d     = RVX_STATE_TRAP_TAKEN;
            trap_commit = 1'b1;
          end else if (take_mret) begin
            state_d     = RVX_STATE_TRAP_RETURN;
            mret_commit = 1'b1;
          end else if (wfi_s1 && !interrupt_pending) begin
            sleeping_d = 1'b1;
          end
        end
        RVX_STATE_TRAP_TAKEN,
        RVX_STATE_TRAP_RETURN: state_d = RVX_STATE_OPERATING;
        default: begin
          state_d    = RVX_STATE_RESET;
          sleeping_d = 1'b0;
          hold_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RVX_STATE_RESET;
      sleeping_q <= 1'b0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      sleeping_q <= sleeping_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign current_state_s1 = state_q;
  assign sleeping         = sleeping_q;
  assign pc_update_enable = !bus_stall && !sleeping_q;
  assign flush_s1         = (state_q != RVX_STATE_OPERATING) || sleeping_q;

endmodule

// File: tb/tb_rvx_core_state_ctrl.sv
// Directed bench for rvx_core_state_ctrl with a 3-edge reset hold.
module tb_rvx_core_state_ctrl;

  localparam logic [3:0] S_RST = 4'b0001;
  localparam logic [3:0] S_OP  = 4'b0010;
  localparam logic [3:0] S_TT  = 4'b0100;
  localparam logic [3:0] S_TR  = 4'b1000;

  logic       clock;
  logic       reset;
  logic       take_trap, take_mret, wfi_s1, interrupt_pending, bus_stall;
  logic [3:0] current_state_s1;
  logic       pc_update_enable, flush_s1, trap_commit, mret_commit, sleeping;

  int n_checks = 0;
  int n_fail   = 0;

  rvx_core_state_ctrl #(.RESET_HOLD_CYCLES(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .take_trap         (take_trap),
    .take_mret         (take_mret),
    .wfi_s1            (wfi_s1),
    .interrupt_pending (interrupt_pending),
    .bus_stall         (bus_stall),
    .current_state_s1  (current_state_s1),
    .pc_update_enable  (pc_update_enable),
    .flush_s1          (flush_s1),
    .trap_commit       (trap_commit),
    .mret_commit       (mret_commit),
    .sleeping          (sleeping)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    take_trap = 1'b0; take_mret = 1'b0; wfi_s1 = 1'b0;
    interrupt_pending = 1'b0; bus_stall = 1'b0;
  endtask

  // Expects reset just released before a rising edge; walks the 3 hold edges.
  task automatic walk_reset_hold(input string tag);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (current_state_s1 !== S_RST) begin
        n_fail++; $display("FAIL %s_hold%0d state: got %b want %b", tag, i, current_state_s1, S_RST);
      end
      n_checks++;
      if (flush_s1 !== 1'b1) begin
        n_fail++; $display("FAIL %s_hold%0d flush: got %b want 1", tag, i, flush_s1);
      end
      tick();
    end
    n_checks++;
    if (current_state_s1 !== S_OP) begin
      n_fail++; $display("FAIL %s_operating state: got %b want %b", tag, current_state_s1, S_OP);
    end
    n_checks++;
    if (flush_s1 !== 1'b0) begin
      n_fail++; $display("FAIL %s_operating flush: got %b want 0", tag, flush_s1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2;
    n_checks++;
    if (current_state_s1 !== S_RST) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", current_state_s1, S_RST);
    end
    n_checks++;
    if (sleeping !== 1'b0 || trap_commit !== 1'b0 || mret_commit !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got sleep=%b tc=%b mc=%b want 0 0 0", sleeping, trap_commit, mret_commit);
    end
    n_checks++;
    if (pc_update_enable !== 1'b1) begin
      n_fail++; $display("FAIL reset_pc_update: got %b want 1", pc_update_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    walk_reset_hold("reset");
  endtask

  task automatic test_trap();
    take_trap = 1'b1;
    #1;
    n_checks++;
    if (trap_commit !== 1'b1 || mret_commit !== 1'b0) begin
      n_fail++; $display("FAIL trap_commit_n: got tc=%b mc=%b want 1 0", trap_commit, mret_commit);
    end
    n_checks++;
    if (flush_s1 !== 1'b0) begin
      n_fail++; $display("FAIL trap_flush_n: got %b want 0", flush_s1);
    end
    tick();
    take_trap = 1'b0;
    #1;
    n_checks++;
    if (current_state_s1 !== S_TT || flush_s1 !== 1'b1 || trap_commit !== 1'b0) begin
      n_fail++; $display("FAIL trap_n1: got st=%b fl=%b tc=%b want %b 1 0", current_state_s1, flush_s1, trap_commit, S_TT);
    end
    tick();
    n_checks++;
    if (current_state_s1 !== S_OP || flush_s1 !== 1'b0) begin
      n_fail++; $display("FAIL trap_n2: got st=%b fl=%b want %b 0", current_state_s1, flush_s1, S_OP);
    end
  endtask

  task automatic test_priority_mret();
    take_trap = 1'b1; take_mret = 1'b1;
    #1;
    n_checks++;
    if (trap_commit !== 1'b1 || mret_commit !== 1'b0) begin
      n_fail++; $display("FAIL prio_commit: got tc=%b mc=%b want 1 0", trap_commit, mret_commit);
    end
    tick();
    take_trap = 1'b0; take_mret = 1'b0;
    n_checks++;
    if (current_state_s1 !== S_TT) begin
      n_fail++; $display("FAIL prio_state: got %b want %b", current_state_s1, S_TT);
    end
    tick();
    take_mret = 1'b1;
    #1;
    n_checks++;
    if (mret_commit !== 1'b1 || trap_commit !== 1'b0) begin
      n_fail++; $display("FAIL mret_commit: got mc=%b tc=%b want 1 0", mret_commit, trap_commit);
    end
    tick();
    take_mret = 1'b0;
    n_checks++;
    if (current_state_s1 !== S_TR || flush_s1 !== 1'b1 || mret_commit !== 1'b0) begin
      n_fail++; $display("FAIL mret_n1: got st=%b fl=%b mc=%b want %b 1 0", current_state_s1, flush_s1, mret_commit, S_TR);
    end
    tick();
    n_checks++;
    if (current_state_s1 !== S_OP) begin
      n_fail++; $display("FAIL mret_n2: got %b want %b", current_state_s1, S_OP);
    end
  endtask

  task automatic test_wfi();
    wfi_s1 = 1'b1;
    #1;
    n_checks++;
    if (sleeping !== 1'b0 || pc_update_enable !== 1'b1) begin
      n_fail++; $display("FAIL wfi_n: got sl=%b pc=%b want 0 1", sleeping, pc_update_enable);
    end
    tick();
    wfi_s1 = 1'b0;
    n_checks++;
    if (sleeping !== 1'b1 || pc_update_enable !== 1'b0 || flush_s1 !== 1'b1 || current_state_s1 !== S_OP) begin
      n_fail++; $display("FAIL wfi_sleep: got sl=%b pc=%b fl=%b st=%b want 1 0 1 %b", sleeping, pc_update_enable, flush_s1, current_state_s1, S_OP);
    end
    take_mret = 1'b1;
    #1;
    n_checks++;
    if (mret_commit !== 1'b0) begin
      n_fail++; $display("FAIL sleep_mret_ignored: got %b want 0", mret_commit);
    end
    tick();
    take_mret = 1'b0;
    n_checks++;
    if (sleeping !== 1'b1 || current_state_s1 !== S_OP) begin
      n_fail++; $display("FAIL sleep_hold: got sl=%b st=%b want 1 %b", sleeping, current_state_s1, S_OP);
    end
    interrupt_pending = 1'b1;
    tick();
    interrupt_pending = 1'b0;
    n_checks++;
    if (sleeping !== 1'b0 || current_state_s1 !== S_OP || pc_update_enable !== 1'b1 || flush_s1 !== 1'b0) begin
      n_fail++; $display("FAIL wake_irq: got sl=%b st=%b pc=%b fl=%b want 0 %b 1 0", sleeping, current_state_s1, pc_update_enable, flush_s1, S_OP);
    end
    wfi_s1 = 1'b1; interrupt_pending = 1'b1;
    tick();
    wfi_s1 = 1'b0; interrupt_pending = 1'b0;
    n_checks++;
    if (sleeping !== 1'b0) begin
      n_fail++; $display("FAIL wfi_irq_nop: got %b want 0", sleeping);
    end
    wfi_s1 = 1'b1;
    tick();
    wfi_s1 = 1'b0;
    take_trap = 1'b1; interrupt_pending = 1'b1;
    #1;
    n_checks++;
    if (trap_commit !== 1'b1) begin
      n_fail++; $display("FAIL wake_trap_commit: got %b want 1", trap_commit);
    end
    tick();
    take_trap = 1'b0; interrupt_pending = 1'b0;
    n_checks++;
    if (current_state_s1 !== S_TT || sleeping !== 1'b0) begin
      n_fail++; $display("FAIL wake_trap_state: got st=%b sl=%b want %b 0", current_state_s1, sleeping, S_TT);
    end
    tick();
  endtask

  task automatic test_stall();
    int loads;
    for (int i = 0; i < 3; i++) begin
      bus_stall = 1'b1; take_trap = 1'b1;
      #1;
      n_checks++;
      if (trap_commit !== 1'b0 || pc_update_enable !== 1'b0) begin
        n_fail++; $display("FAIL stall%0d_commit: got tc=%b pc=%b want 0 0", i, trap_commit, pc_update_enable);
      end
      tick();
      n_checks++;
      if (current_state_s1 !== S_OP) begin
        n_fail++; $display("FAIL stall%0d_state: got %b want %b", i, current_state_s1, S_OP);
      end
    end
    bus_stall = 1'b0;
    #1;
    n_checks++;
    if (trap_commit !== 1'b1 || pc_update_enable !== 1'b1) begin
      n_fail++; $display("FAIL unstall_commit: got tc=%b pc=%b want 1 1", trap_commit, pc_update_enable);
    end
    tick();
    take_trap = 1'b0;
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      bus_stall = (i < 2);
      #1;
      n_checks++;
      if (current_state_s1 !== S_TT || flush_s1 !== 1'b1) begin
        n_fail++; $display("FAIL tt_hold%0d: got st=%b fl=%b want %b 1", i, current_state_s1, flush_s1, S_TT);
      end
      if (pc_update_enable === 1'b1) loads++;
      tick();
      if (current_state_s1 !== S_TT) break;
    end
    bus_stall = 1'b0;
    n_checks++;
    if (loads !== 1 || current_state_s1 !== S_OP) begin
      n_fail++; $display("FAIL tt_pc_loads: got loads=%0d st=%b want 1 %b", loads, current_state_s1, S_OP);
    end
  endtask

  task automatic test_async_reset();
    take_trap = 1'b1;
    tick();
    take_trap = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (current_state_s1 !== S_RST || flush_s1 !== 1'b1) begin
      n_fail++; $display("FAIL areset_tt: got st=%b fl=%b want %b 1", current_state_s1, flush_s1, S_RST);
    end
    reset = 1'b0;
    walk_reset_hold("areset_tt");
    wfi_s1 = 1'b1;
    tick();
    wfi_s1 = 1'b0;
    take_trap = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (current_state_s1 !== S_RST || sleeping !== 1'b0 || trap_commit !== 1'b0 || pc_update_enable !== 1'b1) begin
      n_fail++; $display("FAIL areset_sleep: got st=%b sl=%b tc=%b pc=%b want %b 0 0 1", current_state_s1, sleeping, trap_commit, pc_update_enable, S_RST);
    end
    take_trap = 1'b0;
    reset = 1'b0;
    walk_reset_hold("areset_sleep");
  endtask

  initial begin
    test_reset();
    test_trap();
    test_priority_mret();
    test_wfi();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvx_core_state_ctrl.md
# rvx_core_state_ctrl

Main sequencing state machine of the RVX core. Produces the `current_state_s1` code that selects the next-PC source (boot address, trap handler, exception return address, sequential/branch target) and the companion PC-update, stage-1 flush, CSR-commit and sleep controls. Sits between the stage-1 decode/CSR trap detection logic and the PC generation mux/PC register.

## Interface

Parameters:
- `RESET_HOLD_CYCLES`, default 1: number of post-reset rising edges spent in RESET before OPERATING; legal range 1..15.

Ports:
- `clock`  input  1  core clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `take_trap`  input  1  stage 1 has an exception or an enabled, pending interrupt to take.
- `take_mret`  input  1  valid MRET in stage 1.
- `wfi_s1`  input  1  valid WFI in stage 1.
- `interrupt_pending`  input  1  any interrupt pending and individually enabled (ignores global MIE).
- `bus_stall`  input  1  memory bus not ready; freezes the core.
- `current_state_s1`  output  4  one of `RVX_STATE_RESET` (4'b0001), `RVX_STATE_OPERATING` (4'b0010), `RVX_STATE_TRAP_TAKEN` (4'b0100), `RVX_STATE_TRAP_RETURN` (4'b1000) from `rvx_constants.vh`.
- `pc_update_enable`  output  1  PC register loads `program_counter_s0` at the next edge.
- `flush_s1`  output  1  stage-1 instruction is converted to a bubble.
- `trap_commit`  output  1  CSR unit writes mepc/mcause/mstatus for a trap this cycle.
- `mret_commit`  output  1  CSR unit restores mstatus for MRET this cycle.
- `sleeping`  output  1  core halted by WFI.

## Operation

- Registers: `state` (4-bit one-hot), `sleeping` flag, hold counter (4-bit). Async reset: state=RESET, sleeping=0, counter=0.
- `bus_stall`=1 freezes all registers; `trap_commit`, `mret_commit` forced 0; `pc_update_enable`=0.
- RESET: counter increments each edge; when counter == RESET_HOLD_CYCLES-1 at an edge, next state OPERATING, counter cleared.
- OPERATING, not sleeping, priority order:
  - `take_trap` -> TRAP_TAKEN; `trap_commit`=1 this cycle.
  - else `take_mret` -> TRAP_RETURN; `mret_commit`=1 this cycle.
  - else `wfi_s1` and !`interrupt_pending` -> stay OPERATING, set `sleeping`.
  - else stay OPERATING (WFI with an interrupt already pending is a NOP).
- OPERATING, sleeping: `take_trap` -> TRAP_TAKEN, clear `sleeping`, `trap_commit`=1; else `interrupt_pending` -> clear `sleeping` (resume at instruction after WFI); else hold.
- TRAP_TAKEN -> OPERATING. TRAP_RETURN -> OPERATING. Unused encodings -> RESET.
- `take_trap`/`take_mret`/`wfi_s1` ignored outside OPERATING.
- `current_state_s1` = `state` register directly (no decoding glitches).
- `pc_update_enable` = !`bus_stall` & !`sleeping`. The WFI cycle itself updates PC, so mepc of a wake-up trap is WFI+4.
- `flush_s1` = 1 when state is RESET, TRAP_TAKEN or TRAP_RETURN, or `sleeping`=1; 0 otherwise. Independent of `bus_stall`.
- `sleeping` output = flag register.

## Timing

- Reset released before edge 0: RESET for RESET_HOLD_CYCLES edges; with default 1, OPERATING after edge 0. PC loads BOOT_ADDRESS at every RESET edge.
- Trap: `take_trap` in cycle N -> `trap_commit` in N (Mealy), TRAP_TAKEN in N+1 (PC loads handler address at end of N+1, stage 1 flushed), OPERATING in N+2.
- MRET: identical with `mret_commit` and TRAP_RETURN.
- WFI in cycle N -> `sleeping`=1 from N+1; `interrupt_pending` in cycle M -> `sleeping`=0 from M+1.
- Stall in TRAP_TAKEN/TRAP_RETURN extends that state one cycle per stalled cycle; exactly one PC load occurs.
- Reset asserted mid-operation: outputs reflect RESET immediately (async), sleeping cleared, any pending commit dropped.

## Test plan

- Reset, RESET_HOLD_CYCLES=3: state 4'b0001 for 3 edges after release, then 4'b0010; `flush_s1`=1 throughout RESET, 0 after.
- `take_trap` pulse cycle N: `trap_commit`=1 only in N, state 4'b0100 in N+1, 4'b0010 in N+2; `flush_s1`=1 only in N+1.
- `take_trap`=`take_mret`=1 together: TRAP_TAKEN, `mret_commit`=0; then `take_mret` alone: `mret_commit`=1, TRAP_RETURN next cycle.
- `wfi_s1`=1, no interrupt: `sleeping`=1 and `pc_update_enable`=0 from next cycle; `interrupt_pending`=1 with `take_trap`=0 -> `sleeping`=0 next cycle, state stays 4'b0010; repeat with `take_trap`=1 -> TRAP_TAKEN, `trap_commit`=1.
- `bus_stall`=1 for 3 cycles overlapping `take_trap`: no `trap_commit` while stalled; commit on first unstalled cycle; TRAP_TAKEN held through a stall, PC loaded once.
- Assert `reset` asynchronously while in TRAP_TAKEN and sleeping=1: state 4'b0001, `sleeping`=0 before next clock edge.
